// File: rtl/pipeline_stage_reg.sv
// Valid/ready pipeline register between two core stages.
// Optional 2-entry skid buffer keeps in_ready purely registered.
module pipeline_stage_reg #(
  parameter int DATA_W  = 160,
  parameter int CTRL_W  = 24,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  starve_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push;
  logic              pop;
  logic              starve;

  assign out_valid  = (state_q != EMPTY);
  assign out_data   = main_data_q;
  assign out_ctrl   = out_valid ? main_ctrl_q : '0;
  assign starve_cnt = cnt_q;

  // Skid mode: ready depends only on state, never on out_ready
  assign in_ready = (SKID_EN != 0) ? (state_q != TWO)
                                   : (!out_valid || out_ready);

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign starve = !out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (push) begin
            if (SKID_EN != 0) begin
              state_d     = TWO;
              skid_data_d = in_data;
              skid_ctrl_d = in_ctrl;
            end
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Saturating count of cycles downstream sat idle
  always_comb begin
    cnt_d = cnt_q;
    if (starve && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: FIFO scoreboard on the skid
// instance, directed checks on a single-register CNT_W=4 instance.
module tb_pipeline_stage_reg;

  typedef struct {
    logic [159:0] d;
    logic [23:0]  c;
  } ent_t;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] in_data;
  logic [23:0]  in_ctrl;
  logic         out_valid;
  logic         out_ready;
  logic [159:0] out_data;
  logic [23:0]  out_ctrl;
  logic [15:0]  starve_cnt;

  logic         b_flush;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [7:0]   b_in_data;
  logic [7:0]   b_in_ctrl;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [7:0]   b_out_data;
  logic [7:0]   b_out_ctrl;
  logic [3:0]   b_starve;

  ent_t         sbq[$];
  logic [159:0] last_d;
  logic [15:0]  m_cnt;
  int           dut_out;
  int           n_cmp;
  int           n_err;

  pipeline_stage_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .starve_cnt(starve_cnt)
  );

  pipeline_stage_reg #(
    .DATA_W(8), .CTRL_W(8), .SKID_EN(0), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .starve_cnt(b_starve)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock: check DUT against the scoreboard, then advance the model
  task automatic tick();
    bit pop_m;
    bit push_m;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== (sbq.size() < 2)) begin
      n_err++;
      $display("FAIL tick_in_ready: got %b want %b",
               in_ready, (sbq.size() < 2));
    end
    if (sbq.size() > 0) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== sbq[0].d ||
          out_ctrl !== sbq[0].c) begin
        n_err++;
        $display("FAIL tick_out: got v=%b d=%h c=%h want v=1 d=%h c=%h",
                 out_valid, out_data, out_ctrl, sbq[0].d, sbq[0].c);
      end
      last_d = sbq[0].d;
    end else begin
      n_cmp++;
      if (out_valid !== 1'b0 || out_ctrl !== '0 ||
          out_data !== last_d) begin
        n_err++;
        $display("FAIL tick_bubble: got v=%b d=%h c=%h want v=0 d=%h c=0",
                 out_valid, out_data, out_ctrl, last_d);
      end
    end
    n_cmp++;
    if (starve_cnt !== m_cnt) begin
      n_err++;
      $display("FAIL tick_starve: got %0d want %0d", starve_cnt, m_cnt);
    end
    if (!rst && out_valid === 1'b1 && out_ready) dut_out++;
    pop_m  = (sbq.size() > 0) && out_ready;
    push_m = in_valid && (sbq.size() < 2);
    @(posedge clk);
    if (rst) begin
      sbq.delete();
      m_cnt  = '0;
      last_d = '0;
    end else begin
      if (sbq.size() == 0 && out_ready && m_cnt != 16'hFFFF) m_cnt++;
      if (flush) begin
        sbq.delete();
      end else begin
        if (pop_m) void'(sbq.pop_front());
        if (push_m) sbq.push_back('{in_data, in_ctrl});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 ||
        out_ctrl !== '0 || starve_cnt !== '0) begin
      n_err++;
      $display("FAIL reset_a: got v=%b r=%b d=%h c=%h s=%0d want 0 1 0 0 0",
               out_valid, in_ready, out_data, out_ctrl, starve_cnt);
    end
    n_cmp++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 ||
        b_out_data !== '0 || b_out_ctrl !== '0 || b_starve !== '0) begin
      n_err++;
      $display("FAIL reset_b: got v=%b r=%b d=%h c=%h s=%0d want 0 1 0 0 0",
               b_out_valid, b_in_ready, b_out_data, b_out_ctrl, b_starve);
    end
    sbq.delete();
    m_cnt  = '0;
    last_d = '0;
    rst    = 1'b0;
  endtask

  task automatic test_streaming();
    int n0;
    n0 = dut_out;
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = 160'(k);
      in_ctrl  = 24'(k * 3);
      tick();
      n_cmp++;
      if (out_data !== 160'(k) || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stream_%0d: got d=%h r=%b want d=%0d r=1",
                 k, out_data, in_ready, k);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (dut_out - n0 != 4) begin
      n_err++;
      $display("FAIL stream_count: got %0d want 4", dut_out - n0);
    end
  endtask

  task automatic test_backpressure();
    int n0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {5{32'hAAAA_0001}};
    in_ctrl   = 24'h00000A;
    tick();
    in_data   = {5{32'hBBBB_0002}};
    in_ctrl   = 24'h00000B;
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || out_data !== {5{32'hAAAA_0001}}) begin
      n_err++;
      $display("FAIL bp_full: got r=%b d=%h want r=0 d=A",
               in_ready, out_data);
    end
    in_data = {5{32'hCCCC_0003}};
    in_ctrl = 24'h00000C;
    tick();
    n0 = dut_out;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (dut_out - n0 != 2) begin
      n_err++;
      $display("FAIL bp_drain: got %0d want 2", dut_out - n0);
    end
  endtask

  task automatic test_flush();
    int n0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 160'(32'h100 + k);
      in_ctrl = 24'(8'h10 + k);
      tick();
    end
    flush   = 1'b1;
    in_data = 160'h0C;
    in_ctrl = 24'h0C0C0C;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || out_ctrl !== '0) begin
      n_err++;
      $display("FAIL flush_kill: got v=%b c=%h want v=0 c=0",
               out_valid, out_ctrl);
    end
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 160'(32'h200 + k);
      in_ctrl = 24'(8'h20 + k);
      tick();
    end
    n0 = dut_out;
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (dut_out - n0 != 1) begin
      n_err++;
      $display("FAIL flush_out: got %0d want 1", dut_out - n0);
    end
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = {5{32'hDEAD_BEEF}};
    in_ctrl   = 24'hFFFFFF;
    tick();
    in_valid = 1'b0;
    in_ctrl  = 24'h0;
    tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_ctrl !== '0 ||
        out_data !== {5{32'hDEAD_BEEF}}) begin
      n_err++;
      $display("FAIL bubble: got v=%b c=%h d=%h want v=0 c=0 d=DEADBEEF",
               out_valid, out_ctrl, out_data);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 160'(32'h300 + k);
      in_ctrl = 24'(8'h30 + k);
      tick();
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 ||
        out_ctrl !== '0 || starve_cnt !== '0) begin
      n_err++;
      $display("FAIL rst_mid: got v=%b r=%b d=%h c=%h s=%0d want 0 1 0 0 0",
               out_valid, in_ready, out_data, out_ctrl, starve_cnt);
    end
    in_data = 160'h0E0E;
    in_ctrl = 24'h00E0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 160'h0E0E) begin
      n_err++;
      $display("FAIL rst_accept: got v=%b d=%h want v=1 d=0e0e",
               out_valid, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_counter();
    out_ready   = 1'b0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (b_starve !== 4'd10) begin
      n_err++;
      $display("FAIL cnt_mid: got %0d want 10", b_starve);
    end
    repeat (10) tick();
    n_cmp++;
    if (b_starve !== 4'd15) begin
      n_err++;
      $display("FAIL cnt_sat: got %0d want 15", b_starve);
    end
  endtask

  task automatic test_single_reg();
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_data   = 8'h5A;
    b_in_ctrl   = 8'hA5;
    tick();
    n_cmp++;
    if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0 ||
        b_out_data !== 8'h5A || b_out_ctrl !== 8'hA5) begin
      n_err++;
      $display("FAIL sr_full: got v=%b r=%b d=%h c=%h want 1 0 5a a5",
               b_out_valid, b_in_ready, b_out_data, b_out_ctrl);
    end
    b_in_data = 8'h66;
    b_in_ctrl = 8'h99;
    tick();
    n_cmp++;
    if (b_out_data !== 8'h5A || b_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL sr_hold: got d=%h r=%b want 5a 0",
               b_out_data, b_in_ready);
    end
    b_out_ready = 1'b1;
    #1;
    n_cmp++;
    if (b_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL sr_ready: got %b want 1", b_in_ready);
    end
    tick();
    n_cmp++;
    if (b_out_valid !== 1'b1 || b_out_data !== 8'h66 ||
        b_out_ctrl !== 8'h99) begin
      n_err++;
      $display("FAIL sr_next: got v=%b d=%h c=%h want 1 66 99",
               b_out_valid, b_out_data, b_out_ctrl);
    end
    b_in_valid = 1'b0;
    tick();
    n_cmp++;
    if (b_out_valid !== 1'b0 || b_out_ctrl !== '0 ||
        b_out_data !== 8'h66) begin
      n_err++;
      $display("FAIL sr_drain: got v=%b d=%h c=%h want 0 66 0",
               b_out_valid, b_out_data, b_out_ctrl);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    dut_out     = 0;
    m_cnt       = '0;
    last_d      = '0;
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_ctrl     = '0;
    out_ready   = 1'b0;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_ctrl   = '0;
    b_out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_reset_mid();
    test_counter();
    test_single_reg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 160: width of the datapath payload (PC, rs1/rs2 data, immediate, instruction).
REQ-002 SHALL have parameter CTRL_W, default 24: width of the control payload (reg_wr, sel_A, sel_B, wb_sel, funct3, alu_op, waddr, opcode).
REQ-003 SHALL have parameter SKID_EN, default 1: 1 selects a 2-entry skid buffer, 0 selects a single register.
REQ-004 SHALL have parameter CNT_W, default 16: width of the starvation counter.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  kill all held entries (branch/jump redirect).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  downstream entry valid.
- out_ready  in  1  downstream accepts an entry.
- out_data  out  DATA_W  held datapath payload.
- out_ctrl  out  CTRL_W  held control payload, gated.
- starve_cnt  out  CNT_W  cycles the downstream was ready but no entry was offered.

Function
REQ-006 SHALL transfer in on a cycle with in_valid && in_ready, and out on a cycle with out_valid && out_ready.
REQ-007 SHALL have a latency of exactly 1 cycle: an entry accepted at edge N appears on out_* after edge N when the stage was empty.
REQ-008 SHALL (SKID_EN=1) implement states EMPTY (no entries), ONE (main entry only) and TWO (main and skid entries).
REQ-009 SHALL (SKID_EN=1) drive in_ready = (state != TWO) from registers only, with no combinational path from out_ready.
REQ-010 SHALL (SKID_EN=1) use these transitions:
- EMPTY + in -> ONE.
- ONE + in + out -> ONE, main loaded with the new entry.
- ONE + in, no out -> TWO, new entry goes to skid.
- ONE + out, no in -> EMPTY.
- TWO + out -> ONE, skid moves to main.
- TWO, no out -> TWO (hold).
REQ-011 SHALL (SKID_EN=0) hold one entry with in_ready = !out_valid || out_ready.
REQ-012 SHALL present entries in strict FIFO order; no entry SHALL be lost or duplicated.
REQ-013 SHALL force out_ctrl to all-zero whenever out_valid=0, so that a bubble never writes the register file or memory.
REQ-014 SHALL hold out_data at its last value while out_valid=0.
REQ-015 SHALL, on flush=1, go to EMPTY (out_valid=0 from the next cycle) and discard any entry presented that cycle, regardless of in_valid or out_ready.
REQ-016 SHALL let an out transfer in the flush cycle still complete, since out_valid and out_ctrl remain visible that cycle.
REQ-017 SHALL increment starve_cnt on each cycle with out_valid=0 && out_ready=1, saturating at 2^CNT_W-1 with no wrap-around.
REQ-018 SHALL keep starve_cnt unchanged during flush cycles, unless the starvation condition also holds that cycle.
REQ-019 SHALL give rst priority over flush, and flush priority over any transfer.

Reset
REQ-020 SHALL, while rst=1 at a rising edge, set state=EMPTY, out_valid=0, in_ready=1, out_data=0, out_ctrl=0, skid contents=0 and starve_cnt=0.
REQ-021 SHALL, when rst asserts mid-operation, discard all held entries with no partial transfer at that edge.
REQ-022 SHALL accept a new entry in the first cycle after rst deasserts.

Verification
REQ-023 SHALL cover streaming: in_valid=1 and out_ready=1 continuously, data 1,2,3,4 -> out_data 1,2,3,4 one cycle later each, in_ready=1 throughout.
REQ-024 SHALL cover backpressure (SKID_EN=1): out_ready=0 while data A,B are offered -> state TWO, in_ready=0, out_data=A; then out_ready=1 -> A, then B, with no loss.
REQ-025 SHALL cover flush: TWO holding A,B, flush=1 with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=0, C never emitted.
REQ-026 SHALL cover bubble gating: in_ctrl=24'hFFFFFF is accepted, then in_valid=0 with out_ready=1 -> after the drain out_ctrl=0 and out_data is unchanged.
REQ-027 SHALL cover the counter: CNT_W=4 with out_ready=1 and idle for 20 cycles -> starve_cnt saturates at 15.
REQ-028 SHALL cover reset mid-stream and SKID_EN=0:
- rst in state TWO -> all outputs at their REQ-020 values.
- SKID_EN=0 with out_ready=0 -> in_ready=0 while full.
